// File: rtl/umi_pkg.sv
// UMI packet field layout shared by the pack (tx) and unpack (rx) paths.
// Keeping the offsets in one place means the two paths cannot drift apart.
package umi_pkg;
   localparam int UMI_UW   = 256;
   localparam int ADDR_W   = 64;
   localparam int CMD_LSB  = 0;
   localparam int CMD_W    = 8;
   localparam int SIZE_LSB = 8;
   localparam int SIZE_W   = 4;
   localparam int OPT_LSB  = 12;
   localparam int OPT_W    = 20;
   localparam int DST_LSB  = 32;
   localparam int SRC_LSB  = 96;
   localparam int DATA_LSB = 160;
   localparam int DATA_W   = UMI_UW - DATA_LSB;

   typedef logic [CMD_W-1:0] umi_cmd_t;
endpackage

// File: rtl/umi_pack_tx_if.sv
// Field-input and packet-output handshakes of umi_pack_tx.
// The slave modport is the assembler's view; master is the host/link side.
interface umi_pack_tx_if
   import umi_pkg::*;
#(
   parameter int AW = 64,
   parameter int UW = UMI_UW,
   parameter int DW = UMI_UW - DATA_LSB
);
   logic                in_valid;
   logic                in_ready;
   umi_cmd_t            in_command;
   logic [SIZE_W-1:0]   in_size;
   logic [OPT_W-1:0]    in_options;
   logic [AW-1:0]       in_dstaddr;
   logic [AW-1:0]       in_srcaddr;
   logic [DW-1:0]       in_data;
   logic                out_valid;
   logic                out_ready;
   logic [UW-1:0]       out_packet;

   modport slave (
      input  in_valid, in_command, in_size, in_options, in_dstaddr, in_srcaddr, in_data,
      output in_ready,
      output out_valid, out_packet,
      input  out_ready
   );

   modport master (
      output in_valid, in_command, in_size, in_options, in_dstaddr, in_srcaddr, in_data,
      input  in_ready,
      input  out_valid, out_packet,
      output out_ready
   );
endinterface

// File: rtl/umi_pack.sv
// Combinational field-to-packet packer, the exact inverse of umi_unpack.
// Addresses narrower than 64 bits are zero-extended into their slots.
module umi_pack
   import umi_pkg::*;
#(
   parameter int AW = 64,
   parameter int UW = UMI_UW,
   parameter int DW = UMI_UW - DATA_LSB
) (
   input  umi_cmd_t          i_command,
   input  logic [SIZE_W-1:0] i_size,
   input  logic [OPT_W-1:0]  i_options,
   input  logic [AW-1:0]     i_dstaddr,
   input  logic [AW-1:0]     i_srcaddr,
   input  logic [DW-1:0]     i_data,
   output logic [UW-1:0]     o_packet
);
   always_comb begin
      o_packet = '0;
      o_packet[CMD_LSB  +: CMD_W]  = i_command;
      o_packet[SIZE_LSB +: SIZE_W] = i_size;
      o_packet[OPT_LSB  +: OPT_W]  = i_options;
      o_packet[DST_LSB  +: ADDR_W] = ADDR_W'(i_dstaddr);
      o_packet[SRC_LSB  +: ADDR_W] = ADDR_W'(i_srcaddr);
      o_packet[DATA_LSB +: DW]     = i_data;
   end
endmodule

// File: rtl/umi_pack_tx.sv
// UMI transmit assembler: packs fields and buffers packets in a 2-entry FIFO (1 cycle latency).
// Optional tx_count output enabled by defining UMI_PACK_TX_COUNT_EN.
module umi_pack_tx
   import umi_pkg::*;
#(
   parameter int AW = 64,
   parameter int UW = UMI_UW,
   parameter int DW = UMI_UW - DATA_LSB
) (
   input  logic          clk,
   input  logic          reset,
   umi_pack_tx_if.slave  bus
`ifdef UMI_PACK_TX_COUNT_EN
   ,
   output logic [31:0]   tx_count
`endif
);
   logic [UW-1:0] w_packet;
   logic          w_push;
   logic          w_pop;

   logic [UW-1:0] r_mem [2];
   logic          r_wptr;
   logic          r_rptr;
   logic [1:0]    r_occ;

   umi_pack #(.AW(AW), .UW(UW), .DW(DW)) u_pack (
      .i_command (bus.in_command),
      .i_size    (bus.in_size),
      .i_options (bus.in_options),
      .i_dstaddr (bus.in_dstaddr),
      .i_srcaddr (bus.in_srcaddr),
      .i_data    (bus.in_data),
      .o_packet  (w_packet)
   );

   // in_ready is gated by reset so nothing is accepted while the FIFO is held clear.
   assign bus.in_ready   = !reset && (r_occ != 2'd2);
   assign bus.out_valid  = (r_occ != 2'd0);
   assign bus.out_packet = r_mem[r_rptr];

   assign w_push = bus.in_valid  && bus.in_ready;
   assign w_pop  = bus.out_valid && bus.out_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wptr   <= 1'b0;
         r_rptr   <= 1'b0;
         r_occ    <= 2'd0;
      end else begin
         if (w_push) begin
            r_mem[r_wptr] <= w_packet;
            r_wptr        <= ~r_wptr;
         end
         if (w_pop) begin
            r_rptr <= ~r_rptr;
         end
         case ({w_push, w_pop})
            2'b10:   r_occ <= r_occ + 2'd1;
            2'b01:   r_occ <= r_occ - 2'd1;
            default: r_occ <= r_occ;
         endcase
      end
   end

`ifdef UMI_PACK_TX_COUNT_EN
   logic [31:0] r_tx_count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_tx_count <= 32'd0;
      end else if (w_pop) begin
         r_tx_count <= r_tx_count + 32'd1;
      end
   end

   assign tx_count = r_tx_count;
`endif
endmodule
